// File: rtl/core_c1_lsu_ctrl.sv
// Load/store sequencer between the EXU and the shared data bus.
// Drives a req/gnt + rvalid handshake, stalls the EXU, aligns read data, flags misalign/timeout.
module core_c1_lsu_ctrl #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_load_req,
  input  logic        lsu_store_req,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_pause,
  output logic        lsu_done,
  output logic [31:0] lsu_load_data,
  output logic        lsu_misalign,
  output logic        lsu_bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q, wdata_q, load_data_q;
  logic [3:0]       be_q, be_calc;
  logic             we_q, misalign_q, bus_err_q;
  logic             req_any, misaligned, timeout, rd_capture, to_err;

  assign req_any = lsu_load_req | lsu_store_req;

  always_comb begin
    misaligned = 1'b0;
    case (lsu_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lsu_addr[0];
      2'b10:   misaligned = |lsu_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    be_calc = 4'b1111;
    case (lsu_size)
      2'b00:   be_calc = 4'b0001 << lsu_addr[1:0];
      2'b01:   be_calc = 4'b0011 << {lsu_addr[1], 1'b0};
      default: be_calc = 4'b1111;
    endcase
  end

  // Counter is 0 in the first REQ cycle, so the abort lands as it steps to TIMEOUT_CYC-1.
  assign timeout    = (cnt == CNT_W'(TIMEOUT_CYC - 2));
  assign rd_capture = ((state == REQ) && dbus_gnt && !we_q && dbus_rvalid) ||
                      ((state == WAIT_R) && dbus_rvalid);
  assign to_err     = timeout && (((state == REQ) && !dbus_gnt) ||
                                  ((state == WAIT_R) && !dbus_rvalid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (req_any) state_nxt = misaligned ? DONE : REQ;
      REQ:    if (dbus_gnt) state_nxt = (we_q || dbus_rvalid) ? DONE : WAIT_R;
              else if (timeout) state_nxt = DONE;
      WAIT_R: if (dbus_rvalid || timeout) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      load_data_q <= '0;
    end else begin
      if (state == IDLE && req_any) begin
        addr_q  <= lsu_addr;
        wdata_q <= lsu_wdata;
        be_q    <= be_calc;
        we_q    <= lsu_store_req;
      end
      if (state == IDLE)                          cnt <= '0;
      else if (state == REQ || state == WAIT_R)   cnt <= cnt + 1'b1;
      misalign_q <= (state == IDLE) && req_any && misaligned;
      bus_err_q  <= to_err;
      if (rd_capture)  load_data_q <= dbus_rdata >> {addr_q[1:0], 3'b000};
      else if (to_err) load_data_q <= '0;
    end
  end

  // Pause is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    lsu_pause     = rst_n && (((state == IDLE) && req_any) || state == REQ || state == WAIT_R);
    lsu_done      = (state == DONE);
    lsu_misalign  = misalign_q;
    lsu_bus_err   = bus_err_q;
    lsu_load_data = load_data_q;
    dbus_req      = (state == REQ);
    dbus_we       = dbus_req && we_q;
    dbus_addr     = dbus_req ? {addr_q[31:2], 2'b00} : 32'h0;
    dbus_be       = dbus_req ? be_q : 4'h0;
    dbus_wdata    = dbus_req ? wdata_q : 32'h0;
  end

endmodule

// File: tb/tb_core_c1_lsu_ctrl.sv
// Scoreboard bench for core_c1_lsu_ctrl: driver queues expectations, monitors check on done / bus grant.
module tb_core_c1_lsu_ctrl;

  logic        clk, rst_n;
  logic        lsu_load_req, lsu_store_req;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [1:0]  lsu_size;
  logic        lsu_pause, lsu_done, lsu_misalign, lsu_bus_err;
  logic [31:0] lsu_load_data;
  logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;

  core_c1_lsu_ctrl #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_load_req(lsu_load_req), .lsu_store_req(lsu_store_req),
    .lsu_addr(lsu_addr), .lsu_size(lsu_size), .lsu_wdata(lsu_wdata),
    .lsu_pause(lsu_pause), .lsu_done(lsu_done), .lsu_load_data(lsu_load_data),
    .lsu_misalign(lsu_misalign), .lsu_bus_err(lsu_bus_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
  );

  typedef struct { logic mis; logic err; logic [31:0] ld; int lat; int t0; string nm; } done_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; string nm; } bus_t;

  done_t done_q[$];
  bus_t  bus_q[$];
  int    n_tests = 0, n_fail = 0;
  int    cyc = 0, req_cycles = 0;
  int    gnt_wait = 0, rv_lag = 0, rv_pend = 0, req_seen = 0;
  logic [31:0] bus_rdata = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Bus slave: grant after gnt_wait REQ cycles (-1 = never), rvalid rv_lag cycles after grant.
  always @(negedge clk) begin
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
    if (!rst_n) begin
      rv_pend  = 0;
      req_seen = 0;
    end else begin
      if (rv_pend > 0) begin
        rv_pend--;
        if (rv_pend == 0) begin dbus_rvalid = 1'b1; dbus_rdata = bus_rdata; end
      end
      if (dbus_req) begin
        if (gnt_wait >= 0 && req_seen == gnt_wait) begin
          dbus_gnt = 1'b1;
          if (!dbus_we) begin
            if (rv_lag == 0) begin dbus_rvalid = 1'b1; dbus_rdata = bus_rdata; end
            else rv_pend = rv_lag;
          end
        end
        req_seen++;
      end else req_seen = 0;
    end
  end

  // Bus monitor
  always @(negedge clk) begin
    #2;
    if (dbus_req) req_cycles++;
    if (dbus_req && dbus_gnt) begin
      if (bus_q.size() == 0) chk("bus_unexpected_grant", 1, 0);
      else begin
        bus_t e;
        e = bus_q.pop_front();
        chk({e.nm, "_we"},    dbus_we,    e.we);
        chk({e.nm, "_addr"},  dbus_addr,  e.addr);
        chk({e.nm, "_be"},    dbus_be,    e.be);
        chk({e.nm, "_wdata"}, dbus_wdata, e.wd);
      end
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    #2;
    if (lsu_done) begin
      if (done_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        done_t e;
        e = done_q.pop_front();
        chk({e.nm, "_misalign"}, lsu_misalign,  e.mis);
        chk({e.nm, "_bus_err"},  lsu_bus_err,   e.err);
        chk({e.nm, "_ldata"},    lsu_load_data, e.ld);
        chk({e.nm, "_latency"},  cyc - e.t0 + 1, e.lat);
      end
    end
  end

  task automatic run_op(input string nm, input logic ld, input logic st, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd, input int gw, input int rl,
                        input logic [31:0] rd, input logic bus_exp, input logic [3:0] ebe,
                        input logic emis, input logic eerr, input logic [31:0] eld,
                        input int elat, input int ereq);
    int r0, waited, pcnt;
    bit seen;
    done_t d;
    bus_t  b;
    gnt_wait  = gw;
    rv_lag    = rl;
    bus_rdata = rd;
    @(negedge clk);
    lsu_load_req  = ld;
    lsu_store_req = st;
    lsu_addr      = a;
    lsu_size      = sz;
    lsu_wdata     = wd;
    d = '{mis: emis, err: eerr, ld: eld, lat: elat, t0: cyc, nm: nm};
    done_q.push_back(d);
    if (bus_exp) begin
      b = '{we: st, addr: {a[31:2], 2'b00}, be: ebe, wd: wd, nm: nm};
      bus_q.push_back(b);
    end
    #1;
    r0 = req_cycles;
    chk({nm, "_pause_issue"}, lsu_pause, 1);
    pcnt = 1; waited = 0; seen = 0;
    while (!seen && waited < 100) begin
      @(negedge clk);
      waited++;
      if (lsu_done) seen = 1;
      else if (lsu_pause) pcnt++;
    end
    if (!seen) chk({nm, "_done_timeout"}, 0, 1);
    else begin
      #1;
      chk({nm, "_pause_done"}, lsu_pause, 0);
      chk({nm, "_pause_cycles"}, pcnt, elat - 1);
      chk({nm, "_req_cycles"}, req_cycles - r0, ereq);
    end
    lsu_load_req  = 1'b0;
    lsu_store_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; lsu_load_req = 0; lsu_store_req = 0;
    lsu_addr = 0; lsu_size = 0; lsu_wdata = 0;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pause", lsu_pause, 0);
    chk("rst_done", lsu_done, 0);
    chk("rst_req", dbus_req, 0);
    chk("rst_ldata", lsu_load_data, 0);
    chk("rst_flags", {lsu_misalign, lsu_bus_err, dbus_we}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    //     name   ld st addr          sz     wdata         gw  rl rdata        bus be      mis err ldata         lat req
    run_op("sw",   0, 1, 32'h1000_0008, 2'b10, 32'hDEADBEEF, 0,  0, 32'h0,        1, 4'b1111, 0, 0, 32'h0,        3,  1);
    run_op("lb",   1, 0, 32'h2000_0003, 2'b00, 32'h0,        0,  2, 32'hAABBCCDD, 1, 4'b1000, 0, 0, 32'h0000_00AA, 5,  1);
    run_op("sb",   0, 1, 32'h3000_0001, 2'b00, 32'h1111_1111, 0, 0, 32'h0,        1, 4'b0010, 0, 0, 32'h0000_00AA, 3,  1);
    run_op("lh",   1, 0, 32'h4000_0002, 2'b01, 32'h0,        0,  0, 32'h12345678, 1, 4'b1100, 0, 0, 32'h0000_1234, 3,  1);
    run_op("lw_w", 1, 0, 32'h5000_0004, 2'b10, 32'h0,        2,  1, 32'hCAFEF00D, 1, 4'b1111, 0, 0, 32'hCAFEF00D, 6,  3);
    run_op("sh_mis", 0, 1, 32'h6000_0001, 2'b01, 32'h0,      0,  0, 32'h0,        0, 4'b0000, 1, 0, 32'hCAFEF00D, 2,  0);
    run_op("sz11", 1, 0, 32'h6000_0000, 2'b11, 32'h0,        0,  0, 32'h0,        0, 4'b0000, 1, 0, 32'hCAFEF00D, 2,  0);
    run_op("lw_mis", 1, 0, 32'h6000_0006, 2'b10, 32'h0,      0,  0, 32'h0,        0, 4'b0000, 1, 0, 32'hCAFEF00D, 2,  0);
    run_op("lw_to", 1, 0, 32'h6000_0010, 2'b10, 32'h0,      -1,  0, 32'h0,        0, 4'b0000, 0, 1, 32'h0,        17, 15);
    run_op("sw_late", 0, 1, 32'h6000_0020, 2'b10, 32'h0BAD_CAFE, 14, 0, 32'h0,   1, 4'b1111, 0, 0, 32'h0,        17, 15);
    run_op("lw_ok", 1, 0, 32'h7000_0000, 2'b10, 32'h0,       0,  0, 32'h01020304, 1, 4'b1111, 0, 0, 32'h01020304, 3,  1);
    run_op("lb1",  1, 0, 32'h7000_0001, 2'b00, 32'h0,        0,  0, 32'h01020304, 1, 4'b0010, 0, 0, 32'h0001_0203, 3,  1);

    // Reset while waiting for read data: access abandoned, no done.
    gnt_wait = 0; rv_lag = 50; bus_rdata = 32'h0;
    @(negedge clk);
    lsu_load_req = 1'b1; lsu_addr = 32'h9000_0000; lsu_size = 2'b10; lsu_wdata = 0;
    begin
      bus_t b;
      b = '{we: 1'b0, addr: 32'h9000_0000, be: 4'b1111, wd: 32'h0, nm: "lw_rst"};
      bus_q.push_back(b);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstw_pause", lsu_pause, 0);
    chk("rstw_done", lsu_done, 0);
    chk("rstw_req", dbus_req, 0);
    chk("rstw_ldata", lsu_load_data, 0);
    chk("rstw_bus", {dbus_be, dbus_we, lsu_misalign, lsu_bus_err}, 0);
    @(negedge clk);
    lsu_load_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("lw_post", 1, 0, 32'h8000_0008, 2'b10, 32'h0, 0, 1, 32'h55AA55AA, 1, 4'b1111, 0, 0, 32'h55AA55AA, 4, 1);

    repeat (3) @(negedge clk);
    chk("done_q_empty", done_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/core_c1_lsu_ctrl.md
Name: core_c1_lsu_ctrl

Overview:
Sequencer between the EXU load/store unit and the shared data bus. It takes one load or store request per instruction and drives a req/gnt + rvalid bus handshake. It stalls the EXU via lsu_pause until the access completes. It also generates byte enables and lane-aligns read data, flagging misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYC, 16, cycles spent in REQ+WAIT_R before the access is aborted with lsu_bus_err; must be >=2.
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
clk  input  1  core clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
lsu_load_req  input  1  load requested this instruction; held while lsu_pause=1
lsu_store_req  input  1  store requested; held while lsu_pause=1; never high together with lsu_load_req
lsu_addr  input  32  byte address (rs1+imm)
lsu_size  input  2  00 byte, 01 half, 10 word, 11 illegal
lsu_wdata  input  32  store data, already lane-replicated upstream
lsu_pause  output  1  EXU stall request
lsu_done  output  1  one-cycle completion pulse
lsu_load_data  output  32  read word shifted right by addr[1:0]*8; sign/zero extension stays in EXU
lsu_misalign  output  1  valid with lsu_done; access was misaligned/illegal, no bus cycle issued
lsu_bus_err  output  1  valid with lsu_done; timeout abort
dbus_req  output  1  bus request
dbus_we  output  1  1 = write
dbus_addr  output  32  word address {addr[31:2],2'b00}
dbus_be  output  4  byte enables
dbus_wdata  output  32  write data
dbus_gnt  input  1  bus accepts request this cycle
dbus_rvalid  input  1  read data valid
dbus_rdata  input  32  read data

Behaviour:
- Reset (async, rst_n=0): state IDLE; counter 0; all outputs 0, including lsu_load_data. Asserting reset mid-access abandons it; no lsu_done is produced.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE, no request: lsu_pause=0 and dbus_req=0.
- IDLE, request present: lsu_pause=1 combinationally in the same cycle. Latch addr, size, we, wdata and be.
  - Misalignment check: size=01 with addr[0]=1; size=10 with addr[1:0]!=0; or size=11.
  - Misaligned: go to DONE with lsu_misalign=1. No bus cycle is issued.
  - Otherwise: go to REQ.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111. Loads drive the same be value.
- REQ: dbus_req=1 with dbus_we/addr/be/wdata driven from registers, stable until gnt.
  - On dbus_gnt, store: go to DONE.
  - On dbus_gnt, load, dbus_rvalid=0: go to WAIT_R.
  - On dbus_gnt, load, dbus_rvalid=1 in the same cycle: capture data and go to DONE.
- WAIT_R: dbus_req=0. On dbus_rvalid, capture dbus_rdata>>(addr[1:0]*8) into lsu_load_data and go to DONE.
- Timeout: counter clears on IDLE->REQ and increments each cycle in REQ/WAIT_R.
  - When it reaches TIMEOUT_CYC-1 without completion: go to DONE with lsu_bus_err=1, dbus_req dropped, lsu_load_data=0.
  - A gnt/rvalid arriving in that same cycle wins, and no error is flagged.
- DONE:
  - lsu_done=1, lsu_pause=0, dbus_req=0; misalign/bus_err valid for this cycle only.
  - Unconditionally go to IDLE. The still-present request is ignored in DONE, since the EXU advances in this cycle.
- lsu_pause=1 in REQ and WAIT_R.
- lsu_load_data holds its value until the next load capture, timeout or reset. Stores do not modify it.
- Latency with zero-wait bus: store 3 cycles (IDLE, REQ, DONE); load 3 cycles with gnt+rvalid together, 4 with rvalid one cycle after gnt.
- Stray dbus_rvalid in IDLE/REQ-without-gnt/DONE is ignored. dbus_gnt outside REQ is ignored.

Test Plan:
- SW addr=0x1000_0008, data 0xDEADBEEF, gnt in first REQ cycle -> dbus_addr=0x1000_0008, be=1111, we=1; lsu_pause high 2 cycles; lsu_done pulse in cycle 3.
- LB addr=0x...0003, gnt then rvalid 2 cycles later with rdata=0xAABBCCDD -> be=1000, lsu_load_data=0x000000AA, lsu_done after rvalid; pause low only in DONE.
- LH addr=0x...0002 with gnt+rvalid same cycle, rdata=0x12345678 -> be=1100, lsu_load_data=0x00001234, done at cycle 3.
- SH addr=0x...0001 -> no dbus_req ever; lsu_done+lsu_misalign in cycle 2; size=11 gives the same result.
- LW with gnt never asserted, TIMEOUT_CYC=16 -> dbus_req high 15 cycles then dropped; lsu_done+lsu_bus_err; lsu_load_data=0; next request proceeds normally.
- rst_n pulled low in WAIT_R, then released -> all outputs 0 immediately; no lsu_done; next LW completes normally.
